seven_segment_dynamic_to_static: RTL

// Converts a time-multiplexed (dynamic) 7-segment bus {abcdefgh, one-hot digit} into
// w_digit independent static segment/dp outputs, one latch set per digit.

---
 rtl/seven_segment_dynamic_to_static.sv | 94 +++++++++
 1 files changed

// File: rtl/seven_segment_dynamic_to_static.sv
// rtl/seven_segment_dynamic_to_static.sv - dynamic 7-segment bus to per-digit static outputs
// Per-digit shadow capture, optional stale timeout, global PWM brightness, registered output stage.
module seven_segment_dynamic_to_static #(
   parameter int w_digit        = 8,
   parameter int seg_active_low = 1,
   parameter int dp_active_low  = 0,
   parameter int timeout_cycles = 500000,
   parameter int w_pwm          = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             abcdefgh,
   input  logic [w_digit-1:0]     digit,
   input  logic [w_pwm-1:0]       brightness,
   output logic [7*w_digit-1:0]   seg_out,
   output logic [w_digit-1:0]     dp_out,
   output logic [w_digit-1:0]     stale
);

   localparam logic [6:0] seg_off = (seg_active_low != 0) ? 7'h7f : 7'h00;
   localparam logic       dp_off  = (dp_active_low != 0);

   logic [w_pwm-1:0] pwm_cnt;
   logic             pwm_on;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pwm_cnt <= '0;
      else     pwm_cnt <= pwm_cnt + 1'b1;
   end

   assign pwm_on = (brightness == '1) || (pwm_cnt < brightness);

   for (genvar i = 0; i < w_digit; i++) begin : g_digit
      logic [7:0] shad;
      logic [6:0] seg_lit;
      logic [6:0] seg_r;
      logic       dp_r;

      if (timeout_cycles > 0) begin : g_timeout
         localparam int w_cnt = $clog2(timeout_cycles + 1);
         localparam logic [w_cnt-1:0] cnt_max  = w_cnt'(timeout_cycles);
         localparam logic [w_cnt-1:0] cnt_last = w_cnt'(timeout_cycles - 1);

         logic [w_cnt-1:0] cnt;
         logic             stale_r;

         // A strobe always wins over expiry; the counter parks at cnt_max once stale.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               shad    <= '0;
               cnt     <= '0;
               stale_r <= 1'b0;
            end else if (digit[i]) begin
               shad    <= abcdefgh;
               cnt     <= '0;
               stale_r <= 1'b0;
            end else if (cnt != cnt_max) begin
               cnt <= cnt + 1'b1;
               if (cnt == cnt_last) begin
                  stale_r <= 1'b1;
                  shad    <= '0;
               end
            end
         end

         assign stale[i] = stale_r;
      end else begin : g_no_timeout
         always_ff @(posedge clk or posedge rst) begin
            if (rst)           shad <= '0;
            else if (digit[i]) shad <= abcdefgh;
         end

         assign stale[i] = 1'b0;
      end

      // Bus order is a..g from bit 7 down; output slice wants a at the lowest bit.
      assign seg_lit = {shad[1], shad[2], shad[3], shad[4], shad[5], shad[6], shad[7]}
                       & {7{pwm_on}};

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            seg_r <= seg_off;
            dp_r  <= dp_off;
         end else begin
            seg_r <= seg_lit ^ seg_off;
            dp_r  <= (shad[0] & pwm_on) ^ dp_off;
         end
      end

      assign seg_out[7*i +: 7] = seg_r;
      assign dp_out[i]         = dp_r;
   end

endmodule
